// File: rtl/motor_ode_solver_tdm_pkg.sv
// Shared types, saturation helper and RK4 weighting constant for the motor ODE solver.
package motor_ode_pkg;

   localparam int MAXW = 128;

   typedef enum logic [1:0] {EULER = 2'd0, RK2 = 2'd1, RK4 = 2'd2} mode_e;
   typedef enum logic [2:0] {IDLE, K1, K2, K3, K4, UPD} fsm_e;

   // round(2^(frac+16)/6); multiplying by it and shifting right by frac+16 divides by six
   function automatic longint c6_of(input int frac);
      return ((64'sd1 <<< (frac + 16)) + 64'sd3) / 64'sd6;
   endfunction

   localparam longint C6 = c6_of(16);

   function automatic logic signed [MAXW-1:0] sat_w(input logic signed [MAXW-1:0] x, input int w);
      logic signed [MAXW-1:0] hi;
      logic signed [MAXW-1:0] lo;
      hi = (MAXW'(1) <<< (w - 1)) - MAXW'(1);
      lo = -hi - MAXW'(1);
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'd0:    return EULER;
         2'd1:    return RK2;
         default: return RK4;
      endcase
   endfunction

endpackage

// File: rtl/motor_ode_solver_tdm_deriv.sv
// Combinational DC-motor derivative: (v, load, i, w) -> h-scaled (di, dw); no state, no flow control.
module dc_motor_deriv
   import motor_ode_pkg::*;
#(
   parameter int          W    = 32,
   parameter int          FRAC = 16,
   parameter logic [W-1:0] H_AV = 32'h00001000,
   parameter logic [W-1:0] H_AR = 32'h0,
   parameter logic [W-1:0] H_AE = 32'h0,
   parameter logic [W-1:0] H_BT = 32'h0,
   parameter logic [W-1:0] H_BF = 32'h0,
   parameter logic [W-1:0] H_BL = 32'h0
) (
   input  logic signed [W-1:0] v_i,
   input  logic signed [W-1:0] load_i,
   input  logic signed [W-1:0] i_i,
   input  logic signed [W-1:0] w_i,
   output logic signed [W-1:0] ki_o,
   output logic signed [W-1:0] kw_o,
   output logic                sat_o
);

   function automatic logic [W:0] clip(input logic signed [MAXW-1:0] e);
      logic signed [MAXW-1:0] s;
      s = sat_w(e, W);
      return {(s != e), s[W-1:0]};
   endfunction

   // One coefficient*state product, rescaled to Q format and clamped to W bits
   function automatic logic [W:0] scale(input logic signed [W-1:0] h, input logic signed [W-1:0] x);
      logic signed [2*W-1:0] p;
      p = (2*W)'(h) * (2*W)'(x);
      p = p >>> FRAC;
      return clip(MAXW'(p));
   endfunction

   logic signed [W-1:0] t_av, t_ar, t_ae, t_bt, t_bf, t_bl;
   logic                s_av, s_ar, s_ae, s_bt, s_bf, s_bl, s_ki, s_kw;
   logic signed [W+1:0] sum_i, sum_w;

   always_comb begin
      {s_av, t_av} = scale($signed(H_AV), v_i);
      {s_ar, t_ar} = scale($signed(H_AR), i_i);
      {s_ae, t_ae} = scale($signed(H_AE), w_i);
      {s_bt, t_bt} = scale($signed(H_BT), i_i);
      {s_bf, t_bf} = scale($signed(H_BF), w_i);
      {s_bl, t_bl} = scale($signed(H_BL), load_i);
      sum_i = (W+2)'(t_av) - (W+2)'(t_ar) - (W+2)'(t_ae);
      sum_w = (W+2)'(t_bt) - (W+2)'(t_bf) - (W+2)'(t_bl);
      {s_ki, ki_o} = clip(MAXW'(sum_i));
      {s_kw, kw_o} = clip(MAXW'(sum_w));
      sat_o = s_av | s_ar | s_ae | s_bt | s_bf | s_bl | s_ki | s_kw;
   end

endmodule

// File: rtl/motor_ode_solver_tdm.sv
// Time-shared Euler/RK2/RK4 stepper for NCH DC-motor models; accept-to-result 3/4/6 cycles.
// in_ready is high only in IDLE (requests elsewhere are ignored); results are a one-cycle pulse, no backpressure.
module motor_ode_solver_tdm
   import motor_ode_pkg::*;
#(
   parameter int          NCH  = 4,
   parameter int          W    = 32,
   parameter int          FRAC = 16,
   parameter logic [W-1:0] H_AV = 32'h00001000,
   parameter logic [W-1:0] H_AR = 32'h0,
   parameter logic [W-1:0] H_AE = 32'h0,
   parameter logic [W-1:0] H_BT = 32'h0,
   parameter logic [W-1:0] H_BF = 32'h0,
   parameter logic [W-1:0] H_BL = 32'h0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [$clog2(NCH)-1:0]     in_ch,
   input  logic [1:0]                 in_mode,
   input  logic signed [W-1:0]        in_v,
   input  logic signed [W-1:0]        in_load,
   output logic                       out_valid,
   output logic [$clog2(NCH)-1:0]     out_ch,
   output logic signed [W-1:0]        out_i,
   output logic signed [W-1:0]        out_w,
   output logic                       out_sat
);

   localparam int CHW = $clog2(NCH);
   localparam int PW  = W + FRAC + 20;
   localparam logic signed [FRAC+16:0] C6V = (FRAC+17)'(c6_of(FRAC));

   function automatic logic [W:0] clip(input logic signed [MAXW-1:0] e);
      logic signed [MAXW-1:0] s;
      s = sat_w(e, W);
      return {(s != e), s[W-1:0]};
   endfunction

   function automatic logic signed [W-1:0] avg(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      logic signed [W:0] s;
      s = (W+1)'(a) + (W+1)'(b);
      return s[W:1];
   endfunction

   function automatic logic signed [MAXW-1:0] rk4_inc(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                                      input logic signed [W-1:0] c, input logic signed [W-1:0] d);
      logic signed [W+2:0]  s;
      logic signed [PW-1:0] p;
      s = (W+3)'(a) + ((W+3)'(b) <<< 1) + ((W+3)'(c) <<< 1) + (W+3)'(d);
      p = PW'(s) * PW'(C6V);
      return MAXW'(p >>> (FRAC + 16));
   endfunction

   fsm_e                state_q, state_d;
   logic [CHW-1:0]      ch_q;
   mode_e               mode_q;
   logic                ch_ok_q;
   logic signed [W-1:0] v_q, load_q;
   logic signed [W-1:0] k1i_q, k1w_q, k2i_q, k2w_q, k3i_q, k3w_q, k4i_q, k4w_q;
   logic                sat_q;
   logic                out_valid_q, out_sat_q;
   logic [CHW-1:0]      out_ch_q;
   logic signed [W-1:0] out_i_q, out_w_q;
   logic signed [W-1:0] i_arr_q [NCH];
   logic signed [W-1:0] w_arr_q [NCH];
   logic signed [W-1:0] vp_arr_q [NCH];
   logic signed [W-1:0] lp_arr_q [NCH];

   logic signed [W-1:0] x_i, x_w, vp, lp, vm, lm;
   logic signed [W-1:0] st_i, st_w, st_v, st_l;
   logic                st_si, st_sw, stage_sat;
   logic signed [W-1:0] dk_i, dk_w;
   logic                d_sat;
   logic signed [W-1:0] new_i, new_w;
   logic                fs_i, fs_w;

   // An invalid channel steps from an all-zero state and is never written back
   always_comb begin
      x_i = '0;
      x_w = '0;
      vp  = '0;
      lp  = '0;
      if (ch_ok_q) begin
         x_i = i_arr_q[ch_q];
         x_w = w_arr_q[ch_q];
         vp  = vp_arr_q[ch_q];
         lp  = lp_arr_q[ch_q];
      end
      vm = avg(vp, v_q);
      lm = avg(lp, load_q);
   end

   always_comb begin
      st_i  = x_i;
      st_w  = x_w;
      st_v  = vp;
      st_l  = lp;
      st_si = 1'b0;
      st_sw = 1'b0;
      case (state_q)
         K2: begin
            {st_si, st_i} = clip(MAXW'(x_i) + MAXW'(k1i_q >>> 1));
            {st_sw, st_w} = clip(MAXW'(x_w) + MAXW'(k1w_q >>> 1));
            st_v = vm;
            st_l = lm;
         end
         K3: begin
            {st_si, st_i} = clip(MAXW'(x_i) + MAXW'(k2i_q >>> 1));
            {st_sw, st_w} = clip(MAXW'(x_w) + MAXW'(k2w_q >>> 1));
            st_v = vm;
            st_l = lm;
         end
         K4: begin
            {st_si, st_i} = clip(MAXW'(x_i) + MAXW'(k3i_q));
            {st_sw, st_w} = clip(MAXW'(x_w) + MAXW'(k3w_q));
            st_v = v_q;
            st_l = load_q;
         end
         default: ;
      endcase
      stage_sat = st_si | st_sw;
   end

   dc_motor_deriv #(
      .W(W), .FRAC(FRAC),
      .H_AV(H_AV), .H_AR(H_AR), .H_AE(H_AE),
      .H_BT(H_BT), .H_BF(H_BF), .H_BL(H_BL)
   ) u_deriv (
      .v_i   (st_v),
      .load_i(st_l),
      .i_i   (st_i),
      .w_i   (st_w),
      .ki_o  (dk_i),
      .kw_o  (dk_w),
      .sat_o (d_sat)
   );

   always_comb begin
      case (mode_q)
         EULER: begin
            {fs_i, new_i} = clip(MAXW'(x_i) + MAXW'(k1i_q));
            {fs_w, new_w} = clip(MAXW'(x_w) + MAXW'(k1w_q));
         end
         RK2: begin
            {fs_i, new_i} = clip(MAXW'(x_i) + MAXW'(k2i_q));
            {fs_w, new_w} = clip(MAXW'(x_w) + MAXW'(k2w_q));
         end
         default: begin
            {fs_i, new_i} = clip(MAXW'(x_i) + rk4_inc(k1i_q, k2i_q, k3i_q, k4i_q));
            {fs_w, new_w} = clip(MAXW'(x_w) + rk4_inc(k1w_q, k2w_q, k3w_q, k4w_q));
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      in_ready = (state_q == IDLE);
      case (state_q)
         IDLE:    if (in_valid) state_d = K1;
         K1:      state_d = (mode_q == EULER) ? UPD : K2;
         K2:      state_d = (mode_q == RK2) ? UPD : K3;
         K3:      state_d = K4;
         K4:      state_d = UPD;
         UPD:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q        <= '0;
         mode_q      <= EULER;
         ch_ok_q     <= 1'b0;
         v_q         <= '0;
         load_q      <= '0;
         {k1i_q, k1w_q, k2i_q, k2w_q} <= '0;
         {k3i_q, k3w_q, k4i_q, k4w_q} <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_i_q     <= '0;
         out_w_q     <= '0;
         out_sat_q   <= 1'b0;
         for (int n = 0; n < NCH; n++) begin
            i_arr_q[n]  <= '0;
            w_arr_q[n]  <= '0;
            vp_arr_q[n] <= '0;
            lp_arr_q[n] <= '0;
         end
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (in_valid) begin
               ch_q    <= in_ch;
               mode_q  <= decode_mode(in_mode);
               ch_ok_q <= (int'(in_ch) < NCH);
               v_q     <= in_v;
               load_q  <= in_load;
               sat_q   <= 1'b0;
            end
            K1: begin
               k1i_q <= dk_i;
               k1w_q <= dk_w;
               sat_q <= sat_q | d_sat | stage_sat;
            end
            K2: begin
               k2i_q <= dk_i;
               k2w_q <= dk_w;
               sat_q <= sat_q | d_sat | stage_sat;
            end
            K3: begin
               k3i_q <= dk_i;
               k3w_q <= dk_w;
               sat_q <= sat_q | d_sat | stage_sat;
            end
            K4: begin
               k4i_q <= dk_i;
               k4w_q <= dk_w;
               sat_q <= sat_q | d_sat | stage_sat;
            end
            UPD: begin
               out_valid_q <= 1'b1;
               out_ch_q    <= ch_q;
               if (ch_ok_q) begin
                  out_i_q           <= new_i;
                  out_w_q           <= new_w;
                  out_sat_q         <= sat_q | fs_i | fs_w;
                  i_arr_q[ch_q]     <= new_i;
                  w_arr_q[ch_q]     <= new_w;
                  vp_arr_q[ch_q]    <= v_q;
                  lp_arr_q[ch_q]    <= load_q;
               end else begin
                  out_i_q   <= '0;
                  out_w_q   <= '0;
                  out_sat_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_i     = out_i_q;
   assign out_w     = out_w_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_motor_ode_solver_tdm.sv
// Bench for motor_ode_solver_tdm: a default instance (NCH=4) and a high-gain instance (NCH=3, load path enabled).
module tb_motor_ode_solver_tdm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        d_in_valid, d_in_ready, d_out_valid, d_out_sat;
   logic [1:0]  d_in_ch, d_in_mode, d_out_ch;
   logic [31:0] d_in_v, d_in_load, d_out_i, d_out_w;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_sat;
   logic [1:0]  s_in_ch, s_in_mode, s_out_ch;
   logic [31:0] s_in_v, s_in_load, s_out_i, s_out_w;

   motor_ode_solver_tdm #(.NCH(4), .H_AV(32'h00001000)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .in_ch(d_in_ch), .in_mode(d_in_mode),
      .in_v(d_in_v), .in_load(d_in_load),
      .out_valid(d_out_valid), .out_ch(d_out_ch), .out_i(d_out_i), .out_w(d_out_w), .out_sat(d_out_sat)
   );

   motor_ode_solver_tdm #(.NCH(3), .H_AV(32'h01000000), .H_BL(32'h00010000)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ch(s_in_ch), .in_mode(s_in_mode),
      .in_v(s_in_v), .in_load(s_in_load),
      .out_valid(s_out_valid), .out_ch(s_out_ch), .out_i(s_out_i), .out_w(s_out_w), .out_sat(s_out_sat)
   );

   bit cur_sel = 1'b0;
   wire        m_ready = cur_sel ? s_in_ready  : d_in_ready;
   wire        m_valid = cur_sel ? s_out_valid : d_out_valid;
   wire        m_sat   = cur_sel ? s_out_sat   : d_out_sat;
   wire [1:0]  m_ch    = cur_sel ? s_out_ch    : d_out_ch;
   wire [31:0] m_i     = cur_sel ? s_out_i     : d_out_i;
   wire [31:0] m_w     = cur_sel ? s_out_w     : d_out_w;

   typedef struct {
      bit          sel;
      logic [1:0]  ch;
      logic [1:0]  mode;
      logic [31:0] v;
      logic [31:0] load;
      logic [31:0] ei;
      logic [31:0] ew;
      logic        es;
      int          lat;
   } vec_t;

   typedef struct {
      logic [1:0]  ch;
      logic [31:0] i;
      logic [31:0] w;
      logic        s;
      int          lat;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic vld, input logic [1:0] ch, input logic [1:0] mode,
                        input logic [31:0] v, input logic [31:0] load);
      if (sel) begin
         s_in_valid = vld; s_in_ch = ch; s_in_mode = mode; s_in_v = v; s_in_load = load;
      end else begin
         d_in_valid = vld; d_in_ch = ch; d_in_mode = mode; d_in_v = v; d_in_load = load;
      end
   endtask

   function automatic vec_t mk(input bit sel, input logic [1:0] ch, input logic [1:0] mode,
                               input logic [31:0] v, input logic [31:0] load, input logic [31:0] ei,
                               input logic [31:0] ew, input logic es, input int lat);
      vec_t t;
      t.sel = sel; t.ch = ch; t.mode = mode; t.v = v; t.load = load;
      t.ei = ei; t.ew = ew; t.es = es; t.lat = lat;
      return t;
   endfunction

   // Issue one request, then scramble the inputs so only the accept-edge values can matter
   task automatic run(input vec_t t, input int idx);
      exp_t e;
      int   n;
      int   rdy_busy;
      bit   seen;
      cur_sel = t.sel;
      @(negedge clk);
      chk($sformatf("in_ready_idle[%0d]", idx), 32'(m_ready), 32'd1);
      drive(t.sel, 1'b1, t.ch, t.mode, t.v, t.load);
      e.ch = t.ch; e.i = t.ei; e.w = t.ew; e.s = t.es; e.lat = t.lat;
      sb.push_back(e);
      @(posedge clk);
      n = 0; seen = 1'b0; rdy_busy = 0;
      while (!seen && n < 12) begin
         @(negedge clk);
         n++;
         if (n == 1) drive(t.sel, 1'b0, ~t.ch, ~t.mode, $urandom, $urandom);
         if (m_valid) seen = 1'b1;
         else if (m_ready) rdy_busy++;
      end
      e = sb.pop_front();
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout[%0d]: no out_valid within %0d cycles", idx, n);
      end else begin
         chk($sformatf("latency[%0d]", idx), 32'(n), 32'(e.lat));
         chk($sformatf("out_ch[%0d]", idx), 32'(m_ch), 32'(e.ch));
         chk($sformatf("out_i[%0d]", idx), m_i, e.i);
         chk($sformatf("out_w[%0d]", idx), m_w, e.w);
         chk($sformatf("out_sat[%0d]", idx), 32'(m_sat), 32'(e.s));
         @(negedge clk);
         chk($sformatf("pulse_len[%0d]", idx), 32'(m_valid), 32'd0);
      end
      chk($sformatf("in_ready_busy[%0d]", idx), 32'(rdy_busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int stray;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_out_valid", 32'(d_out_valid), 32'd0);
      chk("rst_in_ready", 32'(d_in_ready), 32'd1);
      chk("rst_out_ch", 32'(d_out_ch), 32'd0);
      chk("rst_out_i", d_out_i, 32'd0);
      chk("rst_out_w", d_out_w, 32'd0);
      chk("rst_out_sat", 32'(d_out_sat), 32'd0);
      chk("rst_sat_out_valid", 32'(s_out_valid), 32'd0);

      // Default instance: di = v_stage/16, dw = 0. First step of a channel sees v_prev = 0.
      tbl.push_back(mk(0, 2'd0, 2'd0, 32'h00010000, 32'h00000005, 32'h00000000, 32'h0, 1'b0, 3));
      tbl.push_back(mk(0, 2'd0, 2'd0, 32'h00010000, 32'h00000000, 32'h00001000, 32'h0, 1'b0, 3));
      tbl.push_back(mk(0, 2'd1, 2'd2, 32'h00010000, 32'h00000000, 32'h00000800, 32'h0, 1'b0, 6));
      tbl.push_back(mk(0, 2'd1, 2'd3, 32'h00010000, 32'h00000000, 32'h00001800, 32'h0, 1'b0, 6));
      tbl.push_back(mk(0, 2'd2, 2'd1, 32'h00020000, 32'h00000000, 32'h00001000, 32'h0, 1'b0, 4));
      tbl.push_back(mk(0, 2'd3, 2'd0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0, 1'b0, 3));
      tbl.push_back(mk(0, 2'd2, 2'd1, 32'h00020000, 32'h00000000, 32'h00003000, 32'h0, 1'b0, 4));
      tbl.push_back(mk(0, 2'd3, 2'd0, 32'hFFFF0000, 32'h00000000, 32'h00000000, 32'h0, 1'b0, 3));
      tbl.push_back(mk(0, 2'd3, 2'd1, 32'hFFFF0000, 32'h00000000, 32'hFFFFF000, 32'h0, 1'b0, 4));
      // High-gain instance: di = 256*v_stage (clamped), dw = -load_stage; channel 3 is out of range
      tbl.push_back(mk(1, 2'd0, 2'd0, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h0, 1'b0, 3));
      tbl.push_back(mk(1, 2'd0, 2'd0, 32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'h0, 1'b1, 3));
      tbl.push_back(mk(1, 2'd0, 2'd2, 32'h80000000, 32'h00000000, 32'h7FFFFF54, 32'h0, 1'b1, 6));
      tbl.push_back(mk(1, 2'd0, 2'd2, 32'h80000000, 32'h00000000, 32'hFFFFFF53, 32'h0, 1'b1, 6));
      tbl.push_back(mk(1, 2'd0, 2'd3, 32'h80000000, 32'h00000000, 32'h80000000, 32'h0, 1'b1, 6));
      tbl.push_back(mk(1, 2'd3, 2'd0, 32'h7FFFFFFF, 32'h00012345, 32'h00000000, 32'h0, 1'b1, 3));
      tbl.push_back(mk(1, 2'd1, 2'd0, 32'h00000000, 32'h00030000, 32'h00000000, 32'h0, 1'b0, 3));
      tbl.push_back(mk(1, 2'd1, 2'd0, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFD0000, 1'b0, 3));
      tbl.push_back(mk(1, 2'd3, 2'd1, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0, 1'b1, 4));

      foreach (tbl[k]) run(tbl[k], k);

      // Reset asserted during the K3 cycle of an RK4 step on channel 0
      cur_sel = 1'b0;
      @(negedge clk);
      drive(1'b0, 1'b1, 2'd0, 2'd2, 32'h00010000, 32'h0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      stray = 0;
      repeat (2) begin
         @(negedge clk);
         if (d_out_valid) stray++;
      end
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (d_out_valid) stray++;
      end
      chk("abort_no_out_valid", 32'(stray), 32'd0);
      chk("abort_in_ready", 32'(d_in_ready), 32'd1);
      run(mk(0, 2'd0, 2'd0, 32'h00000000, 32'h0, 32'h00000000, 32'h0, 1'b0, 3), 100);
      run(mk(1, 2'd0, 2'd0, 32'h00000000, 32'h0, 32'h00000000, 32'h0, 1'b0, 3), 101);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
